// File: rtl/result_unloader_if.sv
// Handshake/bus bundle for result_unloader: capture request, flat result matrix,
// and the element stream with its status flags.
`timescale 1ns/1ps
interface result_unloader_if #(
    parameter int W = 32,
    parameter int N = 3
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic                  i_start;
    logic [2*W*N*N-1:0]    i_C;
    logic                  i_ready;
    logic                  o_valid;
    logic [2*W-1:0]        o_data;
    logic [IW-1:0]         o_row;
    logic [IW-1:0]         o_col;
    logic                  o_last;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_overrun;

    modport slave (
        input  i_start, i_C, i_ready,
        output o_valid, o_data, o_row, o_col, o_last, o_busy, o_done, o_overrun
    );

    modport master (
        output i_start, i_C, i_ready,
        input  o_valid, o_data, o_row, o_col, o_last, o_busy, o_done, o_overrun
    );
endinterface

// File: rtl/result_unloader.sv
// Captures an N x N matrix of 2W-bit results and streams it out one element per
// ready/valid transfer. Define UNLOADER_TRANSPOSE_EN for column-major order.
`timescale 1ns/1ps
module result_unloader #(
    parameter int W = 32,
    parameter int N = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    result_unloader_if.slave  bus
);
    localparam int EW = 2 * W;
    localparam int NE = N * N;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int KW = (NE > 1) ? $clog2(NE) : 1;
    localparam logic [IW-1:0] LAST_POS = IW'(N - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t        state_q, state_d;
    logic [EW-1:0] buf_q [NE];
    logic [IW-1:0] row_q, row_d;
    logic [IW-1:0] col_q, col_d;
    logic          done_q, done_d;
    logic          overrun_q, overrun_d;
    logic          capture;
    logic          at_end;
    logic [KW-1:0] idx;

    always_comb begin
        at_end = (row_q == LAST_POS) && (col_q == LAST_POS);
        idx    = KW'(row_q) * KW'(N) + KW'(col_q);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    // Buffer content is don't-care after reset, so it carries no reset branch.
    always_ff @(posedge i_clk) begin
        if (capture) begin
            for (int unsigned k = 0; k < NE; k++) begin
                buf_q[k] <= bus.i_C[k*EW +: EW];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    capture = 1'b1;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (bus.i_start) begin
                    overrun_d = 1'b1;
                end
                if (bus.i_ready) begin
                    if (at_end) begin
                        state_d = IDLE;
                        row_d   = '0;
                        col_d   = '0;
                        done_d  = 1'b1;
                    end else begin
`ifdef UNLOADER_TRANSPOSE_EN
                        if (row_q == LAST_POS) begin
                            row_d = '0;
                            col_d = col_q + 1'b1;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
`else
                        if (col_q == LAST_POS) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
`endif
                    end
                end
            end
        endcase
    end

    always_comb begin
        bus.o_busy    = (state_q == STREAM);
        bus.o_valid   = (state_q == STREAM);
        bus.o_last    = (state_q == STREAM) && at_end;
        bus.o_data    = (state_q == STREAM) ? buf_q[idx] : '0;
        bus.o_row     = row_q;
        bus.o_col     = col_q;
        bus.o_done    = done_q;
        bus.o_overrun = overrun_q;
    end
endmodule

// File: tb/tb_result_unloader.sv
// Directed self-checking bench for result_unloader (W=32, N=3), both orderings.
`timescale 1ns/1ps
module tb_result_unloader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc;
    int   order_k [9];
    logic [63:0] elem [9];

    result_unloader_if #(.W(32), .N(3)) bus ();

    result_unloader #(.W(32), .N(3)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_c();
        for (int k = 0; k < 9; k++) bus.i_C[k*64 +: 64] = elem[k];
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, 69'({bus.o_valid, bus.o_last, bus.o_busy, bus.o_done, bus.o_overrun,
                      bus.o_row, bus.o_col, bus.o_data}), 69'(0));
    endtask

    // Checks transfers first..first+count-1; pat 0 = always ready, 1 = ready 1,0,0,1 repeating.
    task automatic xfer(input int first, input int count, input int pat, output int cycles);
        int n;
        int k;
        logic [68:0] held;
        logic stalled;
        n = first;
        cycles = 0;
        stalled = 1'b0;
        held = '0;
        while (n < first + count) begin
            if (cycles >= 100) begin
                chk("xfer_timeout", 69'(n), 69'(first + count));
                break;
            end
            bus.i_ready = (pat == 0) ? 1'b1 : ((cycles % 4 == 0) || (cycles % 4 == 3));
            if (stalled) chk("stall_hold", {bus.o_data, bus.o_row, bus.o_col, bus.o_last}, held);
            stalled = 1'b0;
            if (bus.o_valid && bus.i_ready) begin
                k = order_k[n];
                chk("data", 69'(bus.o_data), 69'(elem[k]));
                chk("pos", 69'({bus.o_row, bus.o_col}), 69'({2'(k / 3), 2'(k % 3)}));
                chk("last", 69'(bus.o_last), 69'(n == 8));
                n++;
            end else if (bus.o_valid) begin
                held = {bus.o_data, bus.o_row, bus.o_col, bus.o_last};
                stalled = 1'b1;
            end else begin
                chk("valid_in_stream", 69'(bus.o_valid), 69'(1));
            end
            step();
            cycles++;
        end
    endtask

    task automatic start_pulse();
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
    endtask

    initial begin
`ifdef UNLOADER_TRANSPOSE_EN
        order_k = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
`else
        order_k = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
`endif
        bus.i_start = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_C = '0;
        rst = 1'b1;
        #12;
        chk_zero("reset_outputs");
        rst = 1'b0;
        step();
        chk_zero("idle_after_reset");

        // Sequential 1..9, always ready; i_C scrambled after capture
        for (int k = 0; k < 9; k++) elem[k] = 64'(k + 1);
        load_c();
        start_pulse();
        bus.i_C = '1;
        chk("t1_valid_latency", 69'({bus.o_valid, bus.o_busy}), 69'(2'b11));
        xfer(0, 9, 0, cyc);
        chk("t1_cycles", 69'(cyc), 69'(9));
        chk("t1_done", 69'({bus.o_done, bus.o_valid, bus.o_busy, bus.o_last}), 69'(4'b1000));

        // Back-to-back start in the o_done cycle, max-value elements
        for (int k = 0; k < 9; k++) elem[k] = 64'hFFFFFFFE00000001;
        load_c();
        start_pulse();
        chk("t2_started", 69'({bus.o_done, bus.o_valid}), 69'(2'b01));
        xfer(0, 9, 0, cyc);
        chk("t2_cycles", 69'(cyc), 69'(9));
        chk("t2_done", 69'({bus.o_done, bus.o_valid}), 69'(2'b10));
        step();
        chk("t2_done_pulse_end", 69'({bus.o_done, bus.o_valid, bus.o_busy}), 69'(0));

        // Stalling ready pattern
        for (int k = 0; k < 9; k++) elem[k] = 64'(k + 1);
        load_c();
        start_pulse();
        xfer(0, 9, 1, cyc);
        chk("t3_done", 69'({bus.o_done, bus.o_valid}), 69'(2'b10));
        step();

        // Overrun: restart attempt with different matrix after transfer 4
        start_pulse();
        xfer(0, 4, 0, cyc);
        bus.i_ready = 1'b0;
        for (int k = 0; k < 9; k++) bus.i_C[k*64 +: 64] = 64'(100 + k);
        start_pulse();
        chk("t4_overrun_set", 69'(bus.o_overrun), 69'(1));
        xfer(4, 5, 0, cyc);
        chk("t4_done", 69'({bus.o_done, bus.o_overrun}), 69'(2'b11));
        step();
        chk("t4_overrun_sticky", 69'(bus.o_overrun), 69'(1));

        // Reset mid-stream after transfer 5, then a fresh stream
        load_c();
        start_pulse();
        xfer(0, 5, 0, cyc);
        rst = 1'b1;
        #1;
        chk_zero("t5_async_reset");
        #2;
        rst = 1'b0;
        step();
        step();
        chk("t5_wait_idle", 69'({bus.o_valid, bus.o_busy, bus.o_done}), 69'(0));
        start_pulse();
        chk("t5_restart_pos", 69'({bus.o_valid, bus.o_row, bus.o_col}), 69'(5'b10000));
        xfer(0, 9, 0, cyc);
        chk("t5_done", 69'({bus.o_done, bus.o_valid, bus.o_overrun}), 69'(3'b100));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
